// File: rtl/bus_bridge_initiator_queue.sv
// Initiator-side bus bridge queue: buffers requests in a small FIFO, issues
// them one at a time on the serial-bus initiator port, tolerates split
// transactions and read data arriving before or after ACK, and turns a
// transaction that never completes into an error response after a timeout.
module bus_bridge_initiator_queue #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int REQ_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic                         req_is_write,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_is_write,
  output logic                         resp_err,
  output logic                         init_req,
  output logic [ADDR_W-1:0]            init_addr_out,
  output logic                         init_addr_out_valid,
  output logic [DATA_W-1:0]            init_data_out,
  output logic                         init_data_out_valid,
  output logic                         init_rw,
  output logic                         init_ready,
  input  logic                         init_grant,
  input  logic [DATA_W-1:0]            init_data_in,
  input  logic                         init_data_in_valid,
  input  logic                         init_ack,
  input  logic                         init_split_ack,
  output logic [$clog2(REQ_DEPTH):0]   queue_count
);

  localparam int PW = $clog2(REQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(REQ_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_RESP_HOLD = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  // FIFO storage and bookkeeping; entry = {is_write, wdata, addr}
  logic [EW-1:0]     r_mem [REQ_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic              r_req_ready;
  logic              w_push, w_pop;
  logic              w_head_wr;
  logic [DATA_W-1:0] w_head_wdata;
  logic [ADDR_W-1:0] w_head_addr;

  // Active transaction context
  logic              r_is_write, r_addr_cap, r_data_cap;
  logic              r_buf_valid, r_pending;
  logic [DATA_W-1:0] r_buf;
  logic [TW-1:0]     r_tmo;

  // Registered bus-side and response-side outputs
  logic              r_init_req, r_addr_valid, r_data_valid, r_init_rw;
  logic [ADDR_W-1:0] r_addr_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_resp_valid, r_resp_is_write, r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  // Completion decode in WAIT_ACK
  logic              w_done, w_timeout, w_set_pending;
  logic [DATA_W-1:0] w_done_rdata;

  assign w_head_wr    = r_mem[r_rptr][EW-1];
  assign w_head_wdata = r_mem[r_rptr][ADDR_W +: DATA_W];
  assign w_head_addr  = r_mem[r_rptr][ADDR_W-1:0];

  assign req_ready           = r_req_ready;
  assign queue_count         = r_count;
  assign init_req            = r_init_req;
  assign init_addr_out       = r_addr_out;
  assign init_addr_out_valid = r_addr_valid;
  assign init_data_out       = r_data_out;
  assign init_data_out_valid = r_data_valid;
  assign init_rw             = r_init_rw;
  assign init_ready          = 1'b1;
  assign resp_valid          = r_resp_valid;
  assign resp_rdata          = r_resp_rdata;
  assign resp_is_write       = r_resp_is_write;
  assign resp_err            = r_resp_err;

  // FIFO push/pop qualification and next occupancy
  always_comb begin
    w_push = req_valid && r_req_ready;
    w_pop  = (r_state == S_IDLE) && (r_count != '0);
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Decide whether the waiting transaction completes, errors out or goes pending
  always_comb begin
    w_done        = 1'b0;
    w_done_rdata  = '0;
    w_set_pending = 1'b0;
    w_timeout     = 1'b0;
    if (r_state == S_WAIT_ACK) begin
      if (init_ack && r_is_write) begin
        w_done = 1'b1;
      end else if (init_ack && init_data_in_valid) begin
        // data and ACK together: the fresh data wins over any buffered byte
        w_done       = 1'b1;
        w_done_rdata = init_data_in;
      end else if ((init_ack || r_pending) && r_buf_valid) begin
        w_done       = 1'b1;
        w_done_rdata = r_buf;
      end else if (init_ack) begin
        w_set_pending = 1'b1;
      end else begin
        w_set_pending = 1'b0;
      end
      // a completion in the expiry cycle takes precedence over the error
      w_timeout = TMO_EN && !w_done && (r_tmo == TMO_LAST);
    end else begin
      w_timeout = 1'b0;
    end
  end

  // Next-state logic of the transaction FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      w_state_nxt = w_pop ? S_SEND : S_IDLE;
      S_SEND:      w_state_nxt = (r_addr_cap && r_data_cap) ? S_WAIT_ACK : S_SEND;
      S_WAIT_ACK:  w_state_nxt = (w_done || w_timeout) ? S_RESP_HOLD : S_WAIT_ACK;
      S_RESP_HOLD: w_state_nxt = resp_ready ? S_IDLE : S_RESP_HOLD;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO pointers, occupancy and registered ready flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt != DEPTH_C);
    end
  end

  // FIFO storage write; contents are meaningless until a push, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {req_is_write, req_wdata, req_addr};
    end
  end

  // Transaction datapath: launch, capture, read buffer, timeout and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_write      <= 1'b0;
      r_addr_cap      <= 1'b0;
      r_data_cap      <= 1'b0;
      r_buf_valid     <= 1'b0;
      r_pending       <= 1'b0;
      r_buf           <= '0;
      r_tmo           <= '0;
      r_init_req      <= 1'b0;
      r_addr_valid    <= 1'b0;
      r_data_valid    <= 1'b0;
      r_init_rw       <= 1'b1;
      r_addr_out      <= '0;
      r_data_out      <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_is_write <= 1'b0;
      r_resp_err      <= 1'b0;
    end else begin
      // read data is only meaningful while a transaction is in flight
      if ((r_state != S_IDLE) && init_data_in_valid) begin
        r_buf       <= init_data_in;
        r_buf_valid <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_buf_valid <= 1'b0;
          r_buf       <= '0;
          r_pending   <= 1'b0;
          r_tmo       <= '0;
          if (w_pop) begin
            r_is_write   <= w_head_wr;
            r_init_rw    <= w_head_wr;
            r_addr_out   <= w_head_addr;
            r_data_out   <= w_head_wdata;
            r_init_req   <= 1'b1;
            r_addr_valid <= 1'b1;
            r_data_valid <= w_head_wr;
            r_addr_cap   <= 1'b0;
            r_data_cap   <= !w_head_wr;   // reads have no write phase
          end
        end
        S_SEND: begin
          if (init_grant && r_addr_valid) begin
            r_addr_cap   <= 1'b1;
            r_addr_valid <= 1'b0;
          end
          if (init_grant && r_data_valid) begin
            r_data_cap   <= 1'b1;
            r_data_valid <= 1'b0;
          end
        end
        S_WAIT_ACK: begin
          if (init_split_ack) r_init_req <= 1'b0;
          if (w_set_pending)  r_pending  <= 1'b1;
          if (w_done) begin
            r_init_req      <= 1'b0;
            r_resp_valid    <= 1'b1;
            r_resp_rdata    <= w_done_rdata;
            r_resp_is_write <= r_is_write;
            r_resp_err      <= 1'b0;
          end else if (w_timeout) begin
            r_init_req      <= 1'b0;
            r_resp_valid    <= 1'b1;
            r_resp_rdata    <= '0;
            r_resp_is_write <= r_is_write;
            r_resp_err      <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_RESP_HOLD: begin
          if (resp_ready) r_resp_valid <= 1'b0;
        end
        default: begin
          r_init_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_bridge_initiator_queue.sv
// Directed + randomized bench for bus_bridge_initiator_queue. A queue of
// pushed requests is the reference; expected responses follow from the
// request type, the read byte the bench drives and whether it withholds ACK.
module tb_bus_bridge_initiator_queue;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_is_write = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_is_write;
  logic          resp_err;
  logic          init_req;
  logic [AW-1:0] init_addr_out;
  logic          init_addr_out_valid;
  logic [DW-1:0] init_data_out;
  logic          init_data_out_valid;
  logic          init_rw;
  logic          init_ready;
  logic          init_grant = 1'b0;
  logic [DW-1:0] init_data_in = '0;
  logic          init_data_in_valid = 1'b0;
  logic          init_ack = 1'b0;
  logic          init_split_ack = 1'b0;
  logic [2:0]    queue_count;

  bus_bridge_initiator_queue #(
    .ADDR_W(AW), .DATA_W(DW), .REQ_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_is_write(req_is_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_is_write(resp_is_write), .resp_err(resp_err),
    .init_req(init_req), .init_addr_out(init_addr_out),
    .init_addr_out_valid(init_addr_out_valid), .init_data_out(init_data_out),
    .init_data_out_valid(init_data_out_valid), .init_rw(init_rw),
    .init_ready(init_ready), .init_grant(init_grant),
    .init_data_in(init_data_in), .init_data_in_valid(init_data_in_valid),
    .init_ack(init_ack), .init_split_ack(init_split_ack),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_init_req"}, init_req, 0);
    chk({tag, "_addr_valid"}, init_addr_out_valid, 0);
    chk({tag, "_data_valid"}, init_data_out_valid, 0);
    chk({tag, "_addr_out"}, init_addr_out, 0);
    chk({tag, "_data_out"}, init_data_out, 0);
    chk({tag, "_init_rw"}, init_rw, 1);
    chk({tag, "_init_ready"}, init_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_resp_is_write"}, resp_is_write, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_queue_count"}, queue_count, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_is_write = w;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("push_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    exp_q.push_back('{addr: a, wdata: d, wr: w});
  endtask

  // mode 0: write ACK at cycle ad; 1: read data at ad, ACK ad+1+x;
  // 2: read data+ACK at ad; 3: read ACK at ad, data ad+1+x;
  // 4: read split at ad, ACK ad+1, data 3 cycles after ACK; 5: no ACK (timeout)
  task automatic serve(input int mode, input int ad, input int x, input logic [DW-1:0] rd);
    req_t e;
    int n = 0;
    int data_c = -1, ack_c = -1, split_c = -1, last, exp_lat, lat, hold;
    logic [DW-1:0] exp_rd;
    logic exp_err;
    while (!init_req && n < 50) begin tick(); n++; end
    chk("req_seen", init_req, 1);
    if (exp_q.size() == 0) begin
      $display("FAIL model_empty observed=0 expected=1");
      $fatal(1, "reference queue empty");
    end
    e = exp_q.pop_front();
    chk("qcount_at_pop", queue_count, exp_q.size());
    chk("addr", init_addr_out, e.addr);
    chk("rw", init_rw, e.wr);
    chk("addr_valid", init_addr_out_valid, 1);
    chk("data_valid", init_data_out_valid, e.wr);
    if (e.wr) chk("wdata", init_data_out, e.wdata);
    init_grant = 1'b1;
    tick();
    chk("addr_valid_drop", init_addr_out_valid, 0);
    chk("data_valid_drop", init_data_out_valid, 0);
    tick();
    init_grant = 1'b0;
    case (mode)
      0: ack_c = ad;
      1: begin data_c = ad; ack_c = ad + 1 + x; end
      2: begin data_c = ad; ack_c = ad; end
      3: begin ack_c = ad; data_c = ad + 1 + x; end
      4: begin split_c = ad; ack_c = ad + 1; data_c = ad + 4; end
      default: ;
    endcase
    if (mode == 5) begin
      exp_err = 1'b1; exp_rd = '0; last = TMO - 1; exp_lat = 0;
    end else begin
      exp_err = 1'b0;
      exp_rd  = e.wr ? '0 : rd;
      last    = (data_c > ack_c) ? data_c : ack_c;
      exp_lat = (data_c > ack_c) ? 1 : 0;
    end
    for (int c = 0; c <= last; c++) begin
      init_ack           = (c == ack_c);
      init_data_in_valid = (c == data_c);
      init_data_in       = (c == data_c) ? rd : DW'($urandom);
      init_split_ack     = (c == split_c);
      tick();
      init_ack = 1'b0; init_data_in_valid = 1'b0; init_split_ack = 1'b0;
      if (c == split_c) chk("split_drops_req", init_req, 0);
      if (c < last) chk("no_early_resp", resp_valid, 0);
    end
    lat = 0;
    while (!resp_valid && lat < 6) begin tick(); lat++; end
    chk("resp_latency", lat, exp_lat);
    chk("req_low_in_resp", init_req, 0);
    hold = $urandom_range(0, 2);
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_is_write", resp_is_write, e.wr);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_err", resp_err, exp_err);
      if (h == hold) resp_ready = 1'b1;
      tick();
    end
    resp_ready = 1'b0;
    chk("resp_drop", resp_valid, 0);
    chk("idle_gap", init_req, 0);
  endtask

  initial begin
    // power-on reset
    tick(); tick();
    chk_reset_outputs("por");
    rst_n = 1'b1;
    tick();

    // write: pop one cycle after the push, ACK two cycles into WAIT_ACK
    push(16'h1234, 8'hA5, 1'b1);
    chk("push_visible_count", queue_count, 1);
    chk("no_req_yet", init_req, 0);
    tick();
    chk("pop_next_cycle", init_req, 1);
    serve(0, 2, 0, 8'h00);

    // minimum write: ACK in first WAIT_ACK cycle
    push(16'hBEEF, 8'h5C, 1'b1);
    serve(0, 0, 0, 8'h00);

    // read, data one cycle before ACK
    push(16'h0010, 8'h00, 1'b0);
    serve(1, 0, 0, 8'h3C);

    // read, data and ACK together
    push(16'h0020, 8'h00, 1'b0);
    serve(2, 1, 0, 8'hC3);

    // read, split then ACK then data three cycles later
    push(16'h0030, 8'h00, 1'b0);
    serve(4, 0, 0, 8'h77);

    // stray read strobe while idle must be discarded
    init_data_in = 8'hEE; init_data_in_valid = 1'b1;
    tick();
    init_data_in_valid = 1'b0;
    push(16'h0040, 8'h00, 1'b0);
    serve(3, 0, 1, 8'h5A);

    // queue full with the bus stalled
    for (int i = 0; i < DEPTH + 1; i++) push(16'h1000 + 16'(i), 8'(8'h10 + i), 1'(i % 2));
    chk("full_count", queue_count, DEPTH);
    chk("full_ready", req_ready, 0);
    req_valid = 1'b1; req_addr = 16'hDEAD; req_wdata = 8'hFF; req_is_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_hold_count", queue_count, DEPTH);
      chk("full_hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (exp_q[0].wr) serve(0, 1, 0, 8'h00);
      else serve(3, 0, 0, 8'(8'h80 + i));
    end

    // timeout, then a normal request completes
    push(16'h2222, 8'h00, 1'b0);
    serve(5, 0, 0, 8'h00);
    push(16'h3333, 8'h99, 1'b1);
    serve(0, 1, 0, 8'h00);

    // completion in the expiry cycle wins over the timeout
    push(16'h4444, 8'h11, 1'b1);
    serve(0, TMO - 1, 0, 8'h00);
    push(16'h5555, 8'h00, 1'b0);
    serve(4, 2, 0, 8'h6B);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      int k;
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) push(AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 9) == 0) serve(5, 0, 0, 8'h00);
        else if (exp_q[0].wr) serve(0, $urandom_range(0, TMO - 1), 0, 8'h00);
        else serve($urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 2), DW'($urandom));
      end
    end

    // reset during WAIT_ACK with two entries queued
    push(16'h6666, 8'h01, 1'b1);
    tick();
    init_grant = 1'b1;
    push(16'h7777, 8'h02, 1'b1);
    push(16'h8888, 8'h03, 1'b0);
    init_grant = 1'b0;
    chk("pre_reset_count", queue_count, 2);
    chk("pre_reset_req", init_req, 1);
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_no_req", init_req, 0);
      chk("post_reset_no_resp", resp_valid, 0);
      chk("post_reset_count", queue_count, 0);
    end

    // recovery after reset
    push(16'h9999, 8'h00, 1'b0);
    serve(2, 0, 0, 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_bridge_initiator_queue.md
# bus_bridge_initiator_queue

Parametrised initiator-side bus bridge interface. It sits between the bridge's request/response channel and the serial-bus initiator port. It buffers up to REQ_DEPTH requests in a FIFO and issues them one at a time on the bus. It handles split transactions and read data arriving before or after ACK, and it returns an error response when a transaction exceeds a configurable timeout.

## Interface
- ADDR_W, 16: address width.
- DATA_W, 8: data width.
- REQ_DEPTH, 4: request FIFO depth, ≥2, power of two.
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT_ACK before an error response; 0 disables the timeout.

- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO not full.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- req_is_write  in  1  1 = write, 0 = read.
- resp_valid  out  1  response held.
- resp_ready  in  1  response consumed.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_is_write  out  1  echo of the request type.
- resp_err  out  1  timeout error.
- init_req  out  1  bus request.
- init_addr_out  out  ADDR_W  active address.
- init_addr_out_valid  out  1  address valid.
- init_data_out  out  DATA_W  active write data.
- init_data_out_valid  out  1  write data valid.
- init_rw  out  1  1 = write.
- init_ready  out  1  tied 1.
- init_grant  in  1  bus grant.
- init_data_in  in  DATA_W  read data.
- init_data_in_valid  in  1  read data strobe.
- init_ack  in  1  transaction acknowledge.
- init_split_ack  in  1  target split.
- queue_count  out  $clog2(REQ_DEPTH)+1  FIFO occupancy.

## Operation
- **Reset values:**
  - Outputs: init_req, both valid outputs, resp_valid, resp_rdata, resp_is_write, resp_err, init_addr_out, init_data_out and queue_count are all 0.
  - init_rw = 1; req_ready = 1.
  - Internal state: FIFO empty, state IDLE, timeout counter 0.
- **FIFO:**
  - Push when req_valid && req_ready; req_ready = (queue_count != REQ_DEPTH).
  - Pop in IDLE when the FIFO is non-empty.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo REQ_DEPTH.
- **States:** IDLE, SEND, WAIT_ACK, RESP_HOLD.
- **IDLE:**
  - Clear the read buffer, the pending-ACK flag and the timeout counter.
  - If the FIFO is non-empty: pop, latch the entry, set init_req=1, init_rw=is_write, addr_valid=1 and data_valid=is_write, then go to SEND.
- **SEND:**
  - Address is captured on the first cycle with init_grant && addr_valid; addr_valid drops on the next edge.
  - Write data is captured the same way.
  - Reads count data as already captured.
  - When both are captured, go to WAIT_ACK.
- **Read buffer:** init_data_in_valid in any non-IDLE state loads the buffer and sets buf_valid. Strobes arriving in IDLE are discarded.
- **WAIT_ACK:**
  - init_split_ack: init_req → 0; stay in WAIT_ACK.
  - init_ack on a write, or on a read with buf_valid: init_req → 0, load the response (err=0), go to RESP_HOLD.
  - init_ack on a read without buf_valid: set the pending flag. The first later cycle with buf_valid completes the response.
  - Read data and ACK in the same cycle: the response uses the incoming init_data_in.
  - Timeout counter increments each cycle in this state. When it reaches TIMEOUT_CYCLES−1 with no completion, load an error response (err=1, rdata=0), drop init_req and go to RESP_HOLD. If completion and expiry coincide, completion wins.
- **RESP_HOLD:** resp_valid=1 with a stable payload; on resp_ready go to IDLE with resp_valid → 0.

## Timing
- A request accepted at edge k into an empty FIFO with the FSM in IDLE pops at edge k+1, so init_req is high from cycle k+1.
- Minimum write transaction, with grant asserted continuously:
  - IDLE→SEND at edge 1.
  - Capture flags set at edge 2.
  - WAIT_ACK at edge 3.
  - An ACK seen in cycle 3 gives resp_valid from edge 4.
- resp_valid is high for at least one cycle. After the resp_ready handshake there is one IDLE cycle before the next pop, so back-to-back transactions are separated by at least one cycle with init_req=0.
- queue_count and req_ready are registered-count based: a push becomes visible one cycle later.
- Synchronous reset mid-transaction returns all outputs to their reset values at the next edge and flushes the FIFO. The in-flight transaction is abandoned without a response.

## Test plan
- **Write:** push addr 0x1234, wdata 0xA5, write; grant held; ACK 2 cycles after WAIT_ACK → init_addr_out=0x1234 and init_data_out=0xA5 while valid; response is_write=1, rdata=0, err=0.
- **Read, data before ACK:** read addr 0x0010; data_in 0x3C one cycle before ACK → resp_rdata=0x3C, err=0.
- **Read, split:** read, then split_ack (init_req drops), then ACK, then data 0x77 three cycles later → a single response with rdata=0x77.
- **Queue full:** push REQ_DEPTH+1 requests with the bus stalled (no grant) → req_ready=0 once queue_count=4. Releasing grant and sending ACKs → responses return in push order; count decrements.
- **Timeout:** TIMEOUT_CYCLES=8; no ACK → resp_err=1 and rdata=0 after 8 WAIT_ACK cycles. A following normal request then completes.
- **Reset:** rst_n low during WAIT_ACK with 2 entries queued → after one edge, outputs are at reset values, queue_count=0 and no response is issued.
